// File: rtl/gpu_pkg.sv
// Shared GPU definitions: LCD mode encodings, memory map constants,
// requester ids and the VRAM/OAM arbiter state encoding.
package gpu_pkg;

  localparam logic [1:0] MODE_HBLANK = 2'd0;
  localparam logic [1:0] MODE_VBLANK = 2'd1;
  localparam logic [1:0] MODE_OAM    = 2'd2;
  localparam logic [1:0] MODE_XFER   = 2'd3;

  localparam logic [15:0] VRAM_BASE = 16'h8000;
  localparam logic [15:0] VRAM_END  = 16'h9FFF;
  localparam logic [15:0] OAM_BASE  = 16'hFE00;
  localparam logic [15:0] OAM_END   = 16'hFE9F;

  typedef enum logic [1:0] {
    REQ_PPU,
    REQ_DMA,
    REQ_CPU
  } req_id_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture,
    StAck
  } arb_state_e;

endpackage

// File: rtl/gpu_addr_decode.sv
// Classifies a 16-bit bus address as VRAM, OAM or unmapped and slices out
// the RAM-local address for each space.
module gpu_addr_decode
  import gpu_pkg::*;
#(
  parameter int unsigned VRAM_AW  = 13,
  parameter int unsigned OAM_AW   = 8,
  parameter int unsigned OAM_SIZE = 160
) (
  input  logic [15:0]        addr,
  output logic               is_vram,
  output logic               is_oam,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [OAM_AW-1:0]  oam_addr
);

  localparam logic [15:0] OamLast = OAM_BASE + 16'(OAM_SIZE - 1);

  assign is_vram   = (addr >= VRAM_BASE) && (addr <= VRAM_END);
  assign is_oam    = (addr >= OAM_BASE) && (addr <= OamLast);
  assign vram_addr = addr[VRAM_AW-1:0];
  assign oam_addr  = addr[OAM_AW-1:0];

endmodule

// File: rtl/vram_oam_arbiter.sv
// Shares the single-port VRAM and OAM between PPU, OAM DMA and CPU, applying
// the LCD-mode access locks to the CPU. Priority is PPU > DMA > CPU.
module vram_oam_arbiter
  import gpu_pkg::*;
#(
  parameter int unsigned VRAM_AW      = 13,
  parameter int unsigned OAM_AW       = 8,
  parameter int unsigned OAM_SIZE     = 160,
  parameter logic [7:0]  BLOCKED_DATA = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode_video,
  input  logic               dma_active,
  input  logic               cpu_req,
  input  logic               cpu_rd_n,
  input  logic               cpu_wr_n,
  input  logic [15:0]        cpu_addr,
  input  logic [7:0]         cpu_di,
  output logic [7:0]         cpu_do,
  output logic               cpu_ack,
  input  logic               ppu_req,
  input  logic [15:0]        ppu_addr,
  output logic [7:0]         ppu_do,
  output logic               ppu_ack,
  input  logic               dma_req,
  input  logic [OAM_AW-1:0]  dma_addr,
  input  logic [7:0]         dma_di,
  output logic               dma_ack,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               vram_re,
  output logic               vram_we,
  output logic [7:0]         vram_wdata,
  input  logic [7:0]         vram_rdata,
  output logic [OAM_AW-1:0]  oam_addr,
  output logic               oam_re,
  output logic               oam_we,
  output logic [7:0]         oam_wdata,
  input  logic [7:0]         oam_rdata
);

  logic               cpu_is_vram, cpu_is_oam, ppu_is_vram, ppu_is_oam;
  logic [VRAM_AW-1:0] cpu_vram_addr, ppu_vram_addr;
  logic [OAM_AW-1:0]  cpu_oam_addr, ppu_oam_addr;

  gpu_addr_decode #(.VRAM_AW(VRAM_AW), .OAM_AW(OAM_AW), .OAM_SIZE(OAM_SIZE)) u_cpu_dec (
    .addr      (cpu_addr),
    .is_vram   (cpu_is_vram),
    .is_oam    (cpu_is_oam),
    .vram_addr (cpu_vram_addr),
    .oam_addr  (cpu_oam_addr)
  );

  gpu_addr_decode #(.VRAM_AW(VRAM_AW), .OAM_AW(OAM_AW), .OAM_SIZE(OAM_SIZE)) u_ppu_dec (
    .addr      (ppu_addr),
    .is_vram   (ppu_is_vram),
    .is_oam    (ppu_is_oam),
    .vram_addr (ppu_vram_addr),
    .oam_addr  (ppu_oam_addr)
  );

  arb_state_e state_q;
  req_id_e    id_q;
  logic       rd_q, sel_oam_q;

  logic vram_locked, oam_locked, cpu_ok, cpu_is_wr, cpu_busy, ppu_busy, ppu_mapped;
  logic cpu_blocked, ppu_unmapped, ppu_go, dma_go, cpu_go;
  logic [7:0] rdata;

  assign vram_locked = (mode_video == MODE_XFER);
  assign oam_locked  = (mode_video == MODE_OAM) || (mode_video == MODE_XFER) || dma_active;
  assign cpu_ok      = (cpu_is_vram && !vram_locked) || (cpu_is_oam && !oam_locked);
  assign cpu_is_wr   = !cpu_wr_n && cpu_rd_n;
  assign ppu_mapped  = ppu_is_vram || ppu_is_oam;

  // A requester already owning the FSM must not also take the fast path.
  assign cpu_busy = (state_q != StIdle) && (id_q == REQ_CPU);
  assign ppu_busy = (state_q != StIdle) && (id_q == REQ_PPU);

  // Holding req through the ack cycle must not retrigger; hence the !ack terms.
  assign cpu_blocked  = cpu_req && !cpu_ok && !cpu_ack && !cpu_busy;
  assign ppu_unmapped = ppu_req && !ppu_mapped && !ppu_ack && !ppu_busy;
  assign ppu_go       = ppu_req && ppu_mapped && !ppu_ack;
  assign dma_go       = dma_req && !dma_ack;
  assign cpu_go       = cpu_req && cpu_ok && !cpu_ack;

  assign rdata = sel_oam_q ? oam_rdata : vram_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      id_q       <= REQ_PPU;
      rd_q       <= 1'b0;
      sel_oam_q  <= 1'b0;
      cpu_do     <= '0;
      cpu_ack    <= 1'b0;
      ppu_do     <= '0;
      ppu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      vram_addr  <= '0;
      vram_re    <= 1'b0;
      vram_we    <= 1'b0;
      vram_wdata <= '0;
      oam_addr   <= '0;
      oam_re     <= 1'b0;
      oam_we     <= 1'b0;
      oam_wdata  <= '0;
    end else begin
      cpu_ack <= 1'b0;
      ppu_ack <= 1'b0;
      dma_ack <= 1'b0;
      if (cpu_blocked) begin
        cpu_ack <= 1'b1;
        cpu_do  <= BLOCKED_DATA;
      end
      if (ppu_unmapped) begin
        ppu_ack <= 1'b1;
        ppu_do  <= 8'h00;
      end
      unique case (state_q)
        StIdle: begin
          if (ppu_go) begin
            id_q      <= REQ_PPU;
            rd_q      <= 1'b1;
            sel_oam_q <= ppu_is_oam;
            state_q   <= StIssue;
            if (ppu_is_oam) begin
              oam_addr <= ppu_oam_addr;
              oam_re   <= 1'b1;
            end else begin
              vram_addr <= ppu_vram_addr;
              vram_re   <= 1'b1;
            end
          end else if (dma_go) begin
            id_q      <= REQ_DMA;
            rd_q      <= 1'b0;
            sel_oam_q <= 1'b1;
            state_q   <= StIssue;
            oam_addr  <= dma_addr;
            oam_wdata <= dma_di;
            oam_we    <= 1'b1;
          end else if (cpu_go) begin
            id_q      <= REQ_CPU;
            rd_q      <= !cpu_is_wr;
            sel_oam_q <= cpu_is_oam;
            state_q   <= StIssue;
            if (cpu_is_oam) begin
              oam_addr  <= cpu_oam_addr;
              oam_wdata <= cpu_di;
              oam_re    <= !cpu_is_wr;
              oam_we    <= cpu_is_wr;
            end else begin
              vram_addr  <= cpu_vram_addr;
              vram_wdata <= cpu_di;
              vram_re    <= !cpu_is_wr;
              vram_we    <= cpu_is_wr;
            end
          end
        end
        StIssue: begin
          vram_re <= 1'b0;
          vram_we <= 1'b0;
          oam_re  <= 1'b0;
          oam_we  <= 1'b0;
          if (rd_q) begin
            state_q <= StCapture;
          end else begin
            state_q <= StAck;
            case (id_q)
              REQ_DMA: dma_ack <= 1'b1;
              REQ_CPU: cpu_ack <= 1'b1;
              default: ppu_ack <= 1'b1;
            endcase
          end
        end
        StCapture: begin
          state_q <= StAck;
          if (id_q == REQ_CPU) begin
            cpu_ack <= 1'b1;
            cpu_do  <= rdata;
          end else begin
            ppu_ack <= 1'b1;
            ppu_do  <= rdata;
          end
        end
        StAck:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_oam_arbiter.sv
// Self-checking bench for vram_oam_arbiter: directed scenarios plus random
// CPU/PPU/DMA transactions against a memory-map level reference model.
module tb_vram_oam_arbiter;

  logic        clk, rst;
  logic [1:0]  mode_video;
  logic        dma_active;
  logic        cpu_req, cpu_rd_n, cpu_wr_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_di, cpu_do;
  logic        cpu_ack;
  logic        ppu_req;
  logic [15:0] ppu_addr;
  logic [7:0]  ppu_do;
  logic        ppu_ack;
  logic        dma_req;
  logic [7:0]  dma_addr, dma_di;
  logic        dma_ack;
  logic [12:0] vram_addr;
  logic        vram_re, vram_we;
  logic [7:0]  vram_wdata, vram_rdata;
  logic [7:0]  oam_addr;
  logic        oam_re, oam_we;
  logic [7:0]  oam_wdata, oam_rdata;

  int n_checks = 0;
  int n_errors = 0;
  int en_cnt   = 0;

  vram_oam_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .mode_video (mode_video),
    .dma_active (dma_active),
    .cpu_req    (cpu_req),
    .cpu_rd_n   (cpu_rd_n),
    .cpu_wr_n   (cpu_wr_n),
    .cpu_addr   (cpu_addr),
    .cpu_di     (cpu_di),
    .cpu_do     (cpu_do),
    .cpu_ack    (cpu_ack),
    .ppu_req    (ppu_req),
    .ppu_addr   (ppu_addr),
    .ppu_do     (ppu_do),
    .ppu_ack    (ppu_ack),
    .dma_req    (dma_req),
    .dma_addr   (dma_addr),
    .dma_di     (dma_di),
    .dma_ack    (dma_ack),
    .vram_addr  (vram_addr),
    .vram_re    (vram_re),
    .vram_we    (vram_we),
    .vram_wdata (vram_wdata),
    .vram_rdata (vram_rdata),
    .oam_addr   (oam_addr),
    .oam_re     (oam_re),
    .oam_we     (oam_we),
    .oam_wdata  (oam_wdata),
    .oam_rdata  (oam_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unwritten RAM locations hold a deterministic pattern.
  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 37 + 11) ^ (a >> 3));
  endfunction

  logic [7:0] vmem [int];
  logic [7:0] omem [int];

  always @(posedge clk) begin
    if (vram_we) vmem[int'(vram_addr)] = vram_wdata;
    if (vram_re)
      vram_rdata <= vmem.exists(int'(vram_addr)) ? vmem[int'(vram_addr)] : init_val(int'(vram_addr));
    if (oam_we) omem[int'(oam_addr)] = oam_wdata;
    if (oam_re)
      oam_rdata <= omem.exists(int'(oam_addr)) ? omem[int'(oam_addr)]
                                               : init_val(int'(oam_addr) + 'h10000);
    if (!rst) en_cnt += int'(vram_re) + int'(vram_we) + int'(oam_re) + int'(oam_we);
  end

  // Reference store, keyed by full bus address.
  logic [7:0] ref_mem [int];

  function automatic logic [7:0] ref_rd(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    if (a >= 'h8000 && a <= 'h9FFF) return init_val(a - 'h8000);
    return init_val(a - 'hFE00 + 'h10000);
  endfunction

  // who: 0 CPU, 1 PPU, 2 DMA (a = 0xFE00 + index)
  function automatic void model(input int who, input logic wr, input int a, input logic [7:0] di,
                                output int lat, output logic [7:0] d, output int en);
    bit in_v, in_o, locked;
    in_v   = (a >= 'h8000) && (a <= 'h9FFF);
    in_o   = (a >= 'hFE00) && (a < 'hFE00 + 160);
    locked = (in_v && mode_video == 2'd3) ||
             (in_o && (mode_video == 2'd2 || mode_video == 2'd3 || dma_active));
    d = 8'h00;
    if (who == 1 && !(in_v || in_o)) begin
      lat = 1; d = 8'h00; en = 0;
    end else if (who == 0 && (!(in_v || in_o) || locked)) begin
      lat = 1; d = 8'hFF; en = 0;
    end else begin
      en = 1;
      if (wr) begin
        lat = 2; ref_mem[a] = di;
      end else begin
        lat = 3; d = ref_rd(a);
      end
    end
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_xact(input int who, input logic wr, input logic [15:0] a,
                          input logic [7:0] di, input int flip, input string tag);
    int exp_lat, exp_en, lat, en0;
    logic [7:0] exp_d, got;
    model(who, wr, int'(a), di, exp_lat, exp_d, exp_en);
    en0 = en_cnt;
    case (who)
      0: begin
        cpu_addr = a; cpu_di = di; cpu_wr_n = !wr; cpu_rd_n = wr; cpu_req = 1'b1;
      end
      1: begin ppu_addr = a; ppu_req = 1'b1; end
      default: begin dma_addr = a[7:0]; dma_di = di; dma_req = 1'b1; end
    endcase
    lat = 0;
    got = 8'h00;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (flip == i) mode_video = 2'd3;
      if (who == 0 && cpu_ack) begin lat = i; got = cpu_do; break; end
      if (who == 1 && ppu_ack) begin lat = i; got = ppu_do; break; end
      if (who == 2 && dma_ack) begin lat = i; break; end
    end
    tick();
    cpu_req = 1'b0; ppu_req = 1'b0; dma_req = 1'b0;
    check({tag, " latency"}, lat, exp_lat);
    if (!wr) check({tag, " data"}, int'(got), int'(exp_d));
    check({tag, " ram enables"}, en_cnt - en0, exp_en);
  endtask

  int         lat_p, lat_d, lat_c, en0, ack_seen;
  logic [7:0] d_p, d_c, e_p, e_c, e_x;
  int         el, ee;
  logic [15:0] ra;
  int         who;
  logic       wr;

  initial begin
    rst = 1'b1; mode_video = 2'd0; dma_active = 1'b0;
    cpu_req = 1'b0; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1; cpu_addr = '0; cpu_di = '0;
    ppu_req = 1'b0; ppu_addr = '0; dma_req = 1'b0; dma_addr = '0; dma_di = '0;
    tick();
    check("reset strobes", int'({cpu_ack, ppu_ack, dma_ack, vram_re, vram_we, oam_re, oam_we}), 0);
    check("reset data", int'({cpu_do, ppu_do, vram_wdata, oam_wdata}), 0);
    check("reset addr", int'({vram_addr, oam_addr}), 0);
    tick();
    rst = 1'b0;
    tick();

    // CPU write then read in HBlank
    run_xact(0, 1'b1, 16'h8123, 8'h5A, 0, "hblank vram write");
    check("vram write landed", int'(vmem.exists('h123) ? vmem['h123] : 8'h00), 'h5A);
    run_xact(0, 1'b0, 16'h8123, 8'h00, 0, "hblank vram read");

    // Transfer mode locks VRAM
    mode_video = 2'd3;
    run_xact(0, 1'b0, 16'h8000, 8'h00, 0, "xfer vram read");
    run_xact(0, 1'b1, 16'h8123, 8'h11, 0, "xfer vram write");
    mode_video = 2'd0;
    run_xact(0, 1'b0, 16'h8123, 8'h00, 0, "vram after dropped write");

    // OAM locks
    mode_video = 2'd2;
    run_xact(0, 1'b0, 16'hFE10, 8'h00, 0, "oam search read");
    mode_video = 2'd1;
    run_xact(0, 1'b0, 16'hFE10, 8'h00, 0, "vblank oam read");
    dma_active = 1'b1;
    run_xact(0, 1'b0, 16'hFE10, 8'h00, 0, "dma-locked oam read");
    dma_active = 1'b0;

    // Unmapped
    run_xact(0, 1'b0, 16'hFEA4, 8'h00, 0, "unmapped FEA4");
    run_xact(0, 1'b0, 16'hC000, 8'h00, 0, "unmapped C000");
    run_xact(1, 1'b0, 16'hC000, 8'h00, 0, "ppu unmapped");

    // Mode change after grant completes normally
    mode_video = 2'd0;
    run_xact(0, 1'b0, 16'h8123, 8'h00, 1, "mode flip after grant");
    mode_video = 2'd0;

    // Three simultaneous requesters
    model(1, 1'b0, 'h8010, 8'h00, el, e_p, ee);
    model(2, 1'b1, 'hFE20, 8'h77, el, e_x, ee);
    model(0, 1'b0, 'h8123, 8'h00, el, e_c, ee);
    ppu_addr = 16'h8010; dma_addr = 8'h20; dma_di = 8'h77;
    cpu_addr = 16'h8123; cpu_rd_n = 1'b0; cpu_wr_n = 1'b1;
    en0 = en_cnt; lat_p = 0; lat_d = 0; lat_c = 0; d_p = 8'h00; d_c = 8'h00;
    ppu_req = 1'b1; dma_req = 1'b1; cpu_req = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (lat_p != 0 && lat_p == i - 1) ppu_req = 1'b0;
      if (lat_d != 0 && lat_d == i - 1) dma_req = 1'b0;
      if (lat_c != 0 && lat_c == i - 1) cpu_req = 1'b0;
      if (ppu_ack && lat_p == 0) begin lat_p = i; d_p = ppu_do; end
      if (dma_ack && lat_d == 0) lat_d = i;
      if (cpu_ack && lat_c == 0) begin lat_c = i; d_c = cpu_do; end
    end
    ppu_req = 1'b0; dma_req = 1'b0; cpu_req = 1'b0;
    check("3way ppu latency", lat_p, 3);
    check("3way dma latency", lat_d, 6);
    check("3way cpu latency", lat_c, 10);
    check("3way ppu data", int'(d_p), int'(e_p));
    check("3way cpu data", int'(d_c), int'(e_c));
    check("3way ram enables", en_cnt - en0, 3);
    mode_video = 2'd1;
    run_xact(0, 1'b0, 16'hFE20, 8'h00, 0, "dma write readback");
    mode_video = 2'd0;

    // Reset during CAPTURE
    cpu_addr = 16'h8123; cpu_rd_n = 1'b0; cpu_wr_n = 1'b1; cpu_req = 1'b1;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("async rst strobes", int'({cpu_ack, ppu_ack, dma_ack, vram_re, vram_we, oam_re, oam_we}), 0);
    check("async rst addr", int'(vram_addr), 0);
    check("async rst cpu_do", int'(cpu_do), 0);
    cpu_req = 1'b0;
    tick();
    rst = 1'b0;
    ack_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      ack_seen += int'(cpu_ack) + int'(ppu_ack) + int'(dma_ack);
    end
    check("no ack after abandoned access", ack_seen, 0);
    run_xact(0, 1'b0, 16'h8123, 8'h00, 0, "fresh read after reset");

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      mode_video = 2'($urandom_range(0, 3));
      dma_active = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: ra = 16'h8000 + 16'($urandom_range(0, 31));
        1: ra = 16'h9FF0 + 16'($urandom_range(0, 15));
        2: ra = 16'hFE00 + 16'($urandom_range(0, 159));
        3: ra = 16'hFE98 + 16'($urandom_range(0, 15));
        4: ra = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'hA000;
        default: ra = 16'($urandom);
      endcase
      who = $urandom_range(0, 3);
      if (who == 3) who = 0;
      wr = 1'($urandom_range(0, 1));
      if (who == 1) wr = 1'b0;
      if (who == 2) begin
        wr = 1'b1;
        ra = 16'hFE00 + 16'($urandom_range(0, 159));
      end
      run_xact(who, wr, ra, 8'($urandom), 0, $sformatf("rand%0d who%0d a%04h", n, who, ra));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
